// File: rtl/remainder.sv
// ---------------------------------------------------------------------------
// remainder
//   Remainder/quotient register and iteration sequencer for a 32-bit
//   sequential restoring divider. Holds the 64-bit working register R, feeds
//   its upper half to the external subtractor and, on each iteration, either
//   keeps Hi (negative difference) or takes the difference, shifting one
//   quotient bit in at the bottom.
//
// Ports
//   clk            in   1   system clock, rising edge
//   rst            in   1   asynchronous active-low reset
//   run            in   1   start / advance enable
//   Dividend       in  32   unsigned dividend, sampled on the load edge
//   ALU_result     in  33   {1'b0,Hi} - {1'b0,divisor}; bit 32 set = negative
//   Hi             out 32   R[63:32], operand to the subtractor
//   Remainder_out  out 32   {1'b0, R[63:33]}
//   Quotient_out   out 32   R[31:0]
//   counting       out  1   high while iterating (CALC)
// ---------------------------------------------------------------------------
module remainder (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] Dividend,
  input  logic [32:0] ALU_result,
  output logic [31:0] Hi,
  output logic [31:0] Remainder_out,
  output logic [31:0] Quotient_out,
  output logic        counting
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [63:0] r_q;
  logic [63:0] r_d;
  logic [5:0]  cnt_q;

  // One restoring-division step. The ALU bit 31 is dropped on purpose: after
  // the shift only 31 bits of the difference fit above the old low word, which
  // is exact for every divisor up to 2^31.
  always_comb begin
    r_d = {r_q[62:0], 1'b0};
    if (!ALU_result[32]) begin
      r_d = {ALU_result[30:0], r_q[31:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            // Load already includes the first left shift.
            r_q     <= {31'b0, Dividend, 1'b0};
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (run) begin
            r_q   <= r_d;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          // Result stays in R; a new division needs run to drop first.
          if (!run) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Hi            = r_q[63:32];
  assign Remainder_out = {1'b0, r_q[63:33]};
  assign Quotient_out  = r_q[31:0];
  assign counting      = (state_q == CALC);

endmodule

// File: tb/tb_remainder.sv
module tb_remainder;

  logic        clk;
  logic        rst;
  logic        run;
  logic [31:0] Dividend;
  logic [32:0] ALU_result;
  logic [31:0] Hi;
  logic [31:0] Remainder_out;
  logic [31:0] Quotient_out;
  logic        counting;

  // Bench-side divider ALU, with an override for single-step tests.
  logic [31:0] divisor;
  logic        alu_force;
  logic [32:0] alu_force_val;

  assign ALU_result = alu_force ? alu_force_val
                                : ({1'b0, Hi} - {1'b0, divisor});

  remainder dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .Dividend      (Dividend),
    .ALU_result    (ALU_result),
    .Hi            (Hi),
    .Remainder_out (Remainder_out),
    .Quotient_out  (Quotient_out),
    .counting      (counting)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one rising edge, then settle past it before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] dividend;
    logic [31:0] div;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
  } vec_t;

  // Full division with the bench ALU; optional pause after a given iteration.
  task automatic divide(input logic [31:0] dvd, input logic [31:0] dvs,
                        input logic [31:0] exp_q, input logic [31:0] exp_r,
                        input int pause_after, input string tag);
    logic [31:0] held_q;
    logic [31:0] held_h;
    alu_force = 1'b0;
    divisor   = dvs;
    Dividend  = dvd;
    run       = 1'b1;
    step();
    check({tag, " counting after load"}, {31'b0, counting}, 32'd1);
    for (int it = 1; it <= 32; it++) begin
      step();
      if (it == pause_after) begin
        run    = 1'b0;
        held_q = Quotient_out;
        held_h = Hi;
        for (int p = 0; p < 3; p++) step();
        check({tag, " paused Q"}, Quotient_out, held_q);
        check({tag, " paused Hi"}, Hi, held_h);
        check({tag, " paused counting"}, {31'b0, counting}, 32'd1);
        run = 1'b1;
      end
      if (it == 31) check({tag, " counting it31"}, {31'b0, counting}, 32'd1);
    end
    check({tag, " Q"}, Quotient_out, exp_q);
    check({tag, " R"}, Remainder_out, exp_r);
    check({tag, " counting done"}, {31'b0, counting}, 32'd0);
    // Holding run in DONE must not start anything.
    step();
    check({tag, " Q held DONE"}, Quotient_out, exp_q);
    run = 1'b0;
    step();
    check({tag, " Q kept IDLE"}, Quotient_out, exp_q);
    $display("%s: %0d / %0d -> Q=%0d R=%0d", tag, dvd, dvs, Quotient_out,
             Remainder_out);
  endtask

  vec_t table_v[6];

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b0;
    run           = 1'b0;
    Dividend      = '0;
    divisor       = 32'd1;
    alu_force     = 1'b0;
    alu_force_val = '0;

    table_v[0] = '{32'd100,        32'd7,          32'd14,         32'd2};
    table_v[1] = '{32'd5,          32'd10,         32'd0,          32'd5};
    table_v[2] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    table_v[3] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF};
    table_v[4] = '{32'h1234_5678,  32'h100,        32'h0012_3456,  32'h78};
    table_v[5] = '{32'd0,          32'd5,          32'd0,          32'd0};

    // Reset state
    #2;
    check("reset Hi", Hi, 32'd0);
    check("reset Q", Quotient_out, 32'd0);
    check("reset R", Remainder_out, 32'd0);
    check("reset counting", {31'b0, counting}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Load
    Dividend = 32'h1234_5678;
    run      = 1'b1;
    step();
    check("load Hi", Hi, 32'd0);
    check("load Q", Quotient_out, 32'h2468_ACF0);
    check("load R", Remainder_out, 32'd0);
    check("load counting", {31'b0, counting}, 32'd1);
    $display("load: Q=0x%08h", Quotient_out);

    // Single negative iteration
    alu_force     = 1'b1;
    alu_force_val = 33'h1_0000_0000;
    step();
    check("iter neg Q", Quotient_out, 32'h48D1_59E0);
    check("iter neg Hi", Hi, 32'd0);
    $display("iter neg: Q=0x%08h", Quotient_out);

    // Fresh load, single non-negative iteration
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    alu_force_val = 33'h0_0000_0000;
    alu_force     = 1'b0;
    run           = 1'b1;
    step();
    alu_force = 1'b1;
    step();
    check("iter pos Q", Quotient_out, 32'h48D1_59E1);
    check("iter pos Hi", Hi, 32'd0);
    $display("iter pos: Q=0x%08h", Quotient_out);
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    run = 1'b0;
    alu_force = 1'b0;
    step();

    // Table-driven divisions
    for (int i = 0; i < 6; i++) begin
      divide(table_v[i].dividend, table_v[i].div, table_v[i].exp_q,
             table_v[i].exp_r, 0, $sformatf("table%0d", i));
    end

    // Pause after iteration 10
    divide(32'd100, 32'd7, 32'd14, 32'd2, 10, "pause");

    // Reset mid-operation after iteration 5
    divisor  = 32'd7;
    Dividend = 32'hDEAD_BEEF;
    run      = 1'b1;
    step();
    for (int it = 0; it < 5; it++) step();
    #2;
    rst = 1'b0;
    #1;
    check("midrst Hi", Hi, 32'd0);
    check("midrst Q", Quotient_out, 32'd0);
    check("midrst R", Remainder_out, 32'd0);
    check("midrst counting", {31'b0, counting}, 32'd0);
    $display("mid-op reset: outputs cleared");
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    step();
    divide(32'd1000, 32'd33, 32'd30, 32'd10, 0, "post-reset");

    // Divisor zero: quotient all ones
    divisor  = 32'd0;
    Dividend = 32'd12345;
    run      = 1'b1;
    for (int it = 0; it < 33; it++) step();
    check("div0 Q", Quotient_out, 32'hFFFF_FFFF);
    run = 1'b0;
    step();

    // Random divisions against plain-arithmetic reference
    for (int i = 0; i < 25; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      if (i % 2 == 0) b = $urandom_range(1000, 1);
      else            b = $urandom_range(32'h8000_0000, 1);
      divide(a, b, a / b, a % b, (i % 5 == 0) ? 17 : 0,
             $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
